hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard controller for a five-stage in-order core. It decides each
//   cycle whether the PC advances and which pipeline registers hold or get a
//   bubble. There are three hazard sources:
//     - a data-memory wait, which freezes IF/ID/EX/MEM (highest priority)
//     - a taken branch resolved in EX, which flushes IF/ID and ID/EX
//     - a load-use dependency, which inserts one bubble into ID/EX
//   A memory wait that runs too long is abandoned and reported through a
//   sticky error flag. Two saturating counters count stall and flush cycles.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   RUN      | normal issue; a memory stall moves to MEM_WAIT
//   MEM_WAIT | waiting on data memory; the wait counter runs here
//
// Ports
//   clk, rst_n                    clock, async active-low reset
//   i_id_rs1, i_id_rs2            source registers of the ID instruction
//   i_id_uses_rs1, i_id_uses_rs2  ID instruction really reads rs1 / rs2
//   i_ex_mem_read, i_ex_rd        EX instruction is a load, and its rd
//   i_ex_branch_taken             EX resolved a taken branch/jump
//   i_mem_req, i_mem_ready        MEM stage access pending / completing
//   o_pc_write                    PC load enable
//   o_ifid_stall, o_ifid_flush    IF/ID hold / bubble
//   o_idex_stall, o_idex_flush    ID/EX hold / bubble
//   o_exmem_stall                 EX/MEM hold
//   o_mem_timeout                 sticky memory-timeout error
//   o_stall_count, o_flush_count  saturating performance counters
module hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_uses_rs1,
  input  logic             i_id_uses_rs2,
  input  logic             i_ex_mem_read,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_branch_taken,
  input  logic             i_mem_req,
  input  logic             i_mem_ready,
  output logic             o_pc_write,
  output logic             o_ifid_stall,
  output logic             o_ifid_flush,
  output logic             o_idex_stall,
  output logic             o_idex_flush,
  output logic             o_exmem_stall,
  output logic             o_mem_timeout,
  output logic [CNT_W-1:0] o_stall_count,
  output logic [CNT_W-1:0] o_flush_count
);

  // The wait counter holds the number of MEM_WAIT cycles already completed,
  // so it only ever needs to reach MEM_TIMEOUT-1.
  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_mem_timeout;
  logic [CNT_W-1:0]  r_stall_count;
  logic [CNT_W-1:0]  r_flush_count;

  logic w_load_use;
  logic w_mem_stall;
  logic w_timeout;
  logic w_freeze;

  assign w_load_use = i_ex_mem_read && (i_ex_rd != 5'd0) &&
                      ((i_id_uses_rs1 && (i_id_rs1 == i_ex_rd)) ||
                       (i_id_uses_rs2 && (i_id_rs2 == i_ex_rd)));

  assign w_mem_stall = i_mem_req && !i_mem_ready;

  // The MEM_TIMEOUT-th MEM_WAIT cycle without ready is the timeout cycle.
  assign w_timeout = (r_state == MEM_WAIT) && w_mem_stall &&
                     (r_wait_cnt == WAIT_LAST);

  // On the timeout cycle the freeze is dropped so the pipeline can move on.
  assign w_freeze = w_mem_stall && !w_timeout;

  always_comb begin
    o_pc_write    = 1'b0;
    o_ifid_stall  = 1'b0;
    o_ifid_flush  = 1'b0;
    o_idex_stall  = 1'b0;
    o_idex_flush  = 1'b0;
    o_exmem_stall = 1'b0;
    if (!rst_n) begin
      // everything held low while in reset
    end else if (w_freeze) begin
      o_ifid_stall  = 1'b1;
      o_idex_stall  = 1'b1;
      o_exmem_stall = 1'b1;
    end else if (i_ex_branch_taken) begin
      o_pc_write   = 1'b1;
      o_ifid_flush = 1'b1;
      o_idex_flush = 1'b1;
    end else if (w_load_use) begin
      o_ifid_stall = 1'b1;
      o_idex_flush = 1'b1;
    end else begin
      o_pc_write = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_mem_stall) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (w_timeout) begin
            r_state       <= RUN;
            r_mem_timeout <= 1'b1;
          end else if (!w_mem_stall) begin
            // ready arrived, or the MEM stage dropped its request
            r_state <= RUN;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        default: r_state <= RUN;
      endcase

      if (!o_pc_write && (r_stall_count != {CNT_W{1'b1}}))
        r_stall_count <= r_stall_count + CNT_W'(1);

      if ((o_ifid_flush || o_idex_flush) && (r_flush_count != {CNT_W{1'b1}}))
        r_flush_count <= r_flush_count + CNT_W'(1);
    end
  end

  assign o_mem_timeout = r_mem_timeout;
  assign o_stall_count = r_stall_count;
  assign o_flush_count = r_flush_count;

endmodule
